// File: rtl/spi_mem_ctrl_if.sv
// CPU-side word bus for spi_mem_ctrl: request strobe, address/data and ready/done handshake.
interface spi_mem_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              cs;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       din;
    logic [15:0]       dout;
    logic              ready;
    logic              done;

    modport master (output cs, we, addr, din, input dout, ready, done);
    modport slave  (input cs, we, addr, din, output dout, ready, done);
endinterface

// File: rtl/spi_mem_ctrl.sv
// Word-access SPI memory controller: each 16-bit CPU access becomes one mode-0
// 40-bit frame {cmd, byte address, data} to a 23LC-style serial SRAM.
module spi_mem_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int CLK_DIV = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_mem_ctrl_if.slave  bus,
    output logic           spi_cs_n,
    output logic           spi_sck,
    output logic           spi_mosi,
    input  logic           spi_miso
);
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

    state_t           state;
    logic [39:0]      frame;
    logic [15:0]      rx;
    logic [5:0]       bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic             is_read;
    logic [15:0]      dout_r;
    logic             ready_r;
    logic             done_r;
    logic             cs_n_r;
    logic             sck_r;
    logic [39:0]      req_frame;
    logic             div_end;

    always_comb begin
        req_frame = {bus.we ? CMD_WRITE : CMD_READ,
                     16'({bus.addr, 1'b0}),
                     bus.we ? bus.din : 16'h0000};
    end

    assign div_end = (div_cnt == DIV_LAST);

    // MOSI is the frame MSB; the frame drains to zero over 40 shifts, so MOSI
    // rests low once the transaction ends.
    assign spi_mosi  = frame[39];
    assign spi_cs_n  = cs_n_r;
    assign spi_sck   = sck_r;
    assign bus.dout  = dout_r;
    assign bus.ready = ready_r;
    assign bus.done  = done_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            frame   <= '0;
            rx      <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            is_read <= 1'b0;
            dout_r  <= '0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            cs_n_r  <= 1'b1;
            sck_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cs) begin
                        frame   <= req_frame;
                        is_read <= !bus.we;
                        ready_r <= 1'b0;
                        cs_n_r  <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= 6'd39;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        sck_r   <= 1'b1;
                        rx      <= {rx[14:0], spi_miso};
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (!div_end) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (sck_r) begin
                            sck_r <= 1'b0;
                            frame <= {frame[38:0], 1'b0};
                        end else if (bit_cnt == 6'd0) begin
                            // End of the low half of the last bit.
                            cs_n_r <= 1'b1;
                            done_r <= 1'b1;
                            if (is_read) dout_r <= rx;
                            state  <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt - 6'd1;
                            sck_r   <= 1'b1;
                            rx      <= {rx[14:0], spi_miso};
                        end
                    end
                end
                DONE: begin
                    ready_r <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Scoreboard bench: two controllers (CLK_DIV=2 and CLK_DIV=1), each with a serial SRAM model.
module tb_spi_mem_ctrl;
    logic clk;
    logic rst_n;

    logic [1:0]       cs_a, we_a;
    logic [1:0][11:0] addr_a;
    logic [1:0][15:0] din_a, dout_a, rep_a, last_dout;
    logic [1:0]       ready_a, done_a, scs_n, sck, mosi, miso;

    int errors = 0;
    int checks = 0;

    logic [39:0] exp_frame_q[$];
    logic [15:0] exp_dout_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int CD = 2 - g;
        spi_mem_ctrl_if #(.ADDR_W(12)) bus ();
        int          rc = 0;
        logic [39:0] rep;

        assign bus.cs    = cs_a[g];
        assign bus.we    = we_a[g];
        assign bus.addr  = addr_a[g];
        assign bus.din   = din_a[g];
        assign dout_a[g]  = bus.dout;
        assign ready_a[g] = bus.ready;
        assign done_a[g]  = bus.done;

        spi_mem_ctrl #(.ADDR_W(12), .CLK_DIV(CD)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .bus      (bus),
            .spi_cs_n (scs_n[g]),
            .spi_sck  (sck[g]),
            .spi_mosi (mosi[g]),
            .spi_miso (miso[g])
        );

        // SRAM model: junk during command/address, reply word in the data phase.
        assign rep = {24'h5A3C96, rep_a[g]};
        always @(posedge sck[g] or posedge scs_n[g]) begin
            if (scs_n[g]) rc <= 0;
            else          rc <= rc + 1;
        end
        assign miso[g] = (rc < 40) ? rep[6'(39 - rc)] : 1'b0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cd(input int g);
        return (g == 0) ? 2 : 1;
    endfunction

    // ---------------- monitor ----------------
    int          cyc = 0;
    int          frames_seen = 0;
    int          lowcnt[2], rises[2], fall_cyc[2], prev_fall[2], last_rise[2];
    logic [39:0] cap[2];
    logic [1:0]  active = '0, sck_prev = '0, done_prev = '0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            for (int g = 0; g < 2; g++) begin
                if (!rst_n) begin
                    active[g]    = 1'b0;
                    sck_prev[g]  = 1'b0;
                    done_prev[g] = 1'b0;
                end else begin
                    if (!scs_n[g]) begin
                        if (!active[g]) begin
                            active[g]    = 1'b1;
                            lowcnt[g]    = 0;
                            rises[g]     = 0;
                            cap[g]       = '0;
                            prev_fall[g] = fall_cyc[g];
                            fall_cyc[g]  = cyc;
                        end
                        lowcnt[g]++;
                        if (sck[g] && !sck_prev[g]) begin
                            rises[g]++;
                            cap[g] = {cap[g][38:0], mosi[g]};
                            if (rises[g] == 1) chk("first_rise", 64'(cyc - fall_cyc[g]), 64'(cd(g)));
                            else               chk("sck_period", 64'(cyc - last_rise[g]), 64'(2 * cd(g)));
                            last_rise[g] = cyc;
                        end
                    end else if (active[g]) begin
                        active[g] = 1'b0;
                        frames_seen++;
                        if (exp_frame_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL frame_unexpected: got %0h expected none", cap[g]);
                        end else begin
                            chk("mosi_frame", 64'(cap[g]), 64'(exp_frame_q.pop_front()));
                        end
                        chk("sck_pulses", 64'(rises[g]), 64'd40);
                        chk("cs_n_low", 64'(lowcnt[g]), 64'(81 * cd(g)));
                    end
                    if (done_a[g]) begin
                        chk("done_time", 64'(cyc - fall_cyc[g]), 64'(81 * cd(g)));
                        chk("done_width", 64'(done_prev[g]), 64'd0);
                        if (exp_dout_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL done_unexpected: got dout %0h expected none", dout_a[g]);
                        end else begin
                            chk("dout", 64'(dout_a[g]), 64'(exp_dout_q.pop_front()));
                        end
                    end
                    sck_prev[g]  = sck[g];
                    done_prev[g] = done_a[g];
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_exp(input int g, input bit w, input logic [15:0] rep, input logic [39:0] frame);
        exp_frame_q.push_back(frame);
        if (w) begin
            exp_dout_q.push_back(last_dout[g]);
        end else begin
            exp_dout_q.push_back(rep);
            last_dout[g] = rep;
        end
    endtask

    task automatic req(input int g, input bit w, input logic [11:0] a, input logic [15:0] d,
                       input logic [15:0] rep, input logic [39:0] frame);
        push_exp(g, w, rep, frame);
        @(posedge clk); #1;
        rep_a[g] = rep;
        cs_a[g] = 1'b1; we_a[g] = w; addr_a[g] = a; din_a[g] = d;
        @(posedge clk); #1;
        cs_a[g] = 1'b0;
        chk("accept_ready", 64'(ready_a[g]), 64'd0);
        chk("accept_cs_n", 64'(scs_n[g]), 64'd0);
        chk("accept_mosi", 64'(mosi[g]), 64'(frame[39]));
    endtask

    task automatic wait_done(input int g);
        int n = 0;
        while (!done_a[g] && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("done_seen", 64'(done_a[g]), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        cs_a = '0; we_a = '0; addr_a = '0; din_a = '0; rep_a = '0; last_dout = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            cs_a = 2'($urandom); we_a = 2'($urandom);
            addr_a[0] = 12'($urandom); addr_a[1] = 12'($urandom);
            din_a[0] = 16'($urandom);  din_a[1] = 16'($urandom);
        end
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_ready", 64'(ready_a[g]), 64'd1);
            chk("rst_done", 64'(done_a[g]), 64'd0);
            chk("rst_dout", 64'(dout_a[g]), 64'h0000);
            chk("rst_cs_n", 64'(scs_n[g]), 64'd1);
            chk("rst_sck", 64'(sck[g]), 64'd0);
            chk("rst_mosi", 64'(mosi[g]), 64'd0);
        end
        cs_a = '0; we_a = '0; addr_a = '0; din_a = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_ready", 64'(ready_a[0]), 64'd1);
        chk("post_rst_cs_n", 64'(scs_n[0]), 64'd1);

        // Write: 02 0024 A5C3
        req(0, 1'b1, 12'h012, 16'hA5C3, 16'h0000, 40'h02_0024_A5C3);
        wait_done(0);
        repeat (5) @(posedge clk);
        #1 chk("write_dout_held", 64'(dout_a[0]), 64'h0000);

        // Abort a read at SCK pulse 20 (no expectation pushed).
        @(posedge clk); #1;
        rep_a[0] = 16'hBEEF;
        cs_a[0] = 1'b1; we_a[0] = 1'b0; addr_a[0] = 12'h100;
        @(posedge clk); #1 cs_a[0] = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk); #1;
            if (rises[0] == 20) break;
        end
        chk("abort_reached_pulse20", 64'(rises[0]), 64'd20);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("abort_cs_n", 64'(scs_n[0]), 64'd1);
        chk("abort_sck", 64'(sck[0]), 64'd0);
        chk("abort_dout", 64'(dout_a[0]), 64'h0000);
        chk("abort_ready", 64'(ready_a[0]), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Read after abort: 03 0FFE 0000, reply 1234
        req(0, 1'b0, 12'h7FF, 16'hFFFF, 16'h1234, 40'h03_0FFE_0000);
        wait_done(0);
        repeat (5) @(posedge clk);
        #1 chk("read_dout_held", 64'(dout_a[0]), 64'h1234);

        // Back-to-back with cs held high and inputs changing while busy.
        push_exp(0, 1'b1, 16'h0000, 40'h02_0780_1357);
        push_exp(0, 1'b0, 16'h8E71, 40'h03_00AA_0000);
        @(posedge clk); #1;
        rep_a[0] = 16'h8E71;
        cs_a[0] = 1'b1; we_a[0] = 1'b1; addr_a[0] = 12'h3C0; din_a[0] = 16'h1357;
        @(posedge clk); #1;
        chk("b2b_first_accept", 64'(ready_a[0]), 64'd0);
        we_a[0] = 1'b0; addr_a[0] = 12'h9A9; din_a[0] = 16'h2222;
        repeat (40) @(posedge clk);
        #1 addr_a[0] = 12'h055; din_a[0] = 16'hFFFF;
        wait_done(0);
        @(posedge clk); @(posedge clk); #1;
        chk("b2b_second_accept", 64'(ready_a[0]), 64'd0);
        cs_a[0] = 1'b0;
        wait_done(0);
        chk("b2b_spacing", 64'(fall_cyc[0] - prev_fall[0]), 64'd164);
        repeat (5) @(posedge clk);
        #1 chk("b2b_dout_held", 64'(dout_a[0]), 64'h8E71);

        // CLK_DIV=1 read: 03 001E 0000, reply FFFF
        req(1, 1'b0, 12'h00F, 16'h0000, 16'hFFFF, 40'h03_001E_0000);
        wait_done(1);
        repeat (3) @(posedge clk);
        #1 chk("cd1_dout", 64'(dout_a[1]), 64'hFFFF);

        repeat (200) @(posedge clk);
        chk("frame_count", 64'(frames_seen), 64'd5);
        chk("frame_q_empty", 64'(exp_frame_q.size()), 64'd0);
        chk("dout_q_empty", 64'(exp_dout_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
